// File: rtl/score_board_ctrl_pkg.sv
// Shared definitions for the score-board controller: FSM state codes,
// letter coding and width helpers for the leaderboard entries.
package score_board_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_NAME  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Default bits per letter code and the code of an empty letter slot.
    localparam int LETTER_W_DEF = 6;
    localparam int BLANK        = 0;

    function automatic int score_w(input int digits);
        return 4 * digits;
    endfunction

    function automatic int name_w(input int name_len, input int letter_w);
        return name_len * letter_w;
    endfunction

    // One leaderboard entry is packed as {score, name}, score in the MSBs.
    function automatic int entry_w(input int digits, input int name_len, input int letter_w);
        return score_w(digits) + name_w(name_len, letter_w);
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/score_board_ctrl_if.sv
// Game-control and leaderboard signal bundle between the sensor/timer side
// (master) and the score-board controller (slave).
interface score_board_ctrl_if
    import score_board_ctrl_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int DEPTH    = 4,
    parameter int NAME_LEN = 5,
    parameter int LETTER_W = LETTER_W_DEF
);
    localparam int SCORE_W = score_w(DIGITS);
    localparam int NAME_W  = name_w(NAME_LEN, LETTER_W);
    localparam int IDX_W   = idx_w(DEPTH);

    logic               go;
    logic               shot;
    logic [1:0]         shot_pts;
    logic               done;
    logic [NAME_W-1:0]  name_in;
    logic               name_vld;
    logic               restart;
    logic [IDX_W-1:0]   rd_idx;
    logic [SCORE_W-1:0] score_bcd;
    logic [SCORE_W-1:0] rd_score;
    logic [NAME_W-1:0]  rd_name;
    logic [IDX_W:0]     new_rank;
    logic [2:0]         state;
    logic               busy;

    modport master (
        output go, shot, shot_pts, done, name_in, name_vld, restart, rd_idx,
        input  score_bcd, rd_score, rd_name, new_rank, state, busy
    );

    modport slave (
        input  go, shot, shot_pts, done, name_in, name_vld, restart, rd_idx,
        output score_bcd, rd_score, rd_name, new_rank, state, busy
    );

endinterface

// File: rtl/score_board_ctrl_bcd_digit_add.sv
// Single BCD digit adder: digit + addend + carry-in, result corrected back
// into 0..9 with a decimal carry-out.
module bcd_digit_add (
    input  logic [3:0] digit,
    input  logic [3:0] addend,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;

    // Binary add, then subtract ten (add six modulo 16) when the digit overflows.
    always_comb begin
        raw  = {1'b0, digit} + {1'b0, addend} + {4'b0000, cin};
        cout = (raw > 5'd9);
        sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
    end

endmodule

// File: rtl/score_board_ctrl.sv
// Arcade game-state controller: game FSM, saturating BCD score counter and a
// DEPTH-entry ranked leaderboard with sequential bottom-up insertion.
module score_board_ctrl
    import score_board_ctrl_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int DEPTH    = 4,
    parameter int NAME_LEN = 5,
    parameter int LETTER_W = LETTER_W_DEF
) (
    input logic               clk,
    input logic               resetn,
    score_board_ctrl_if.slave bus
);
    localparam int SCORE_W = score_w(DIGITS);
    localparam int NAME_W  = name_w(NAME_LEN, LETTER_W);
    localparam int ENTRY_W = entry_w(DIGITS, NAME_LEN, LETTER_W);
    localparam int IDX_W   = idx_w(DEPTH);
    localparam int RANK_W  = IDX_W + 1;

    localparam logic [RANK_W-1:0]  NO_RANK    = RANK_W'(DEPTH);
    localparam logic [SCORE_W-1:0] ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [NAME_W-1:0]  BLANK_NAME = {NAME_LEN{LETTER_W'(BLANK)}};
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DEPTH - 1);

    state_e              state_q, state_nxt;
    logic [SCORE_W-1:0]  score_q;
    logic [NAME_W-1:0]   name_q;
    logic [RANK_W-1:0]   new_rank_q;
    logic [RANK_W-1:0]   rank_calc;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    prev_idx;
    logic                ptr_hit;
    logic [ENTRY_W-1:0]  entry_q [DEPTH];

    logic [SCORE_W-1:0]  addend_vec;
    logic [SCORE_W-1:0]  sum_bcd;
    logic [DIGITS:0]     carry;

    // ------------------------------------------------------------------
    // BCD ripple adder: shot points enter at the ones digit only.
    // ------------------------------------------------------------------
    assign addend_vec = {{(SCORE_W - 2){1'b0}}, bus.shot_pts};
    assign carry[0]   = 1'b0;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit_add u_digit (
            .digit  (score_q[4*d +: 4]),
            .addend (addend_vec[4*d +: 4]),
            .cin    (carry[d]),
            .sum    (sum_bcd[4*d +: 4]),
            .cout   (carry[d+1])
        );
    end

    // Rank search: lowest index whose stored score is strictly beaten.
    always_comb begin
        rank_calc = NO_RANK;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (score_q > entry_q[i][ENTRY_W-1 -: SCORE_W]) begin
                rank_calc = RANK_W'(i);
            end
        end
        // An empty game must not displace blank slots either.
        if (score_q == '0) begin
            rank_calc = NO_RANK;
        end
    end

    assign prev_idx = ptr_q - IDX_W'(1);
    assign ptr_hit  = ({1'b0, ptr_q} == new_rank_q);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode; inputs not listed for a state are ignored there.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (bus.go)       state_nxt = ST_PLAY;
            ST_PLAY:  if (bus.done)     state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = (rank_calc != NO_RANK) ? ST_NAME : ST_DONE;
            ST_NAME:  if (bus.name_vld) state_nxt = ST_SHIFT;
            ST_SHIFT: if (ptr_hit)      state_nxt = ST_DONE;
            ST_DONE:  if (bus.restart)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Score, rank, name capture and one leaderboard move per SHIFT cycle.
    // NOTE: the leaderboard array is reset explicitly because it must read
    // as blank entries straight after resetn, not as uninitialised storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q    <= '0;
            name_q     <= BLANK_NAME;
            new_rank_q <= NO_RANK;
            ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= {{SCORE_W{1'b0}}, BLANK_NAME};
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.go) score_q <= '0;
                end
                ST_PLAY: begin
                    if (bus.shot && (bus.shot_pts != 2'd0)) begin
                        score_q <= carry[DIGITS] ? ALL_NINES : sum_bcd;
                    end
                end
                ST_CHECK: begin
                    new_rank_q <= rank_calc;
                end
                ST_NAME: begin
                    if (bus.name_vld) begin
                        name_q <= bus.name_in;
                        ptr_q  <= LAST_IDX;
                    end
                end
                ST_SHIFT: begin
                    if (ptr_hit) begin
                        entry_q[ptr_q] <= {score_q, name_q};
                    end else begin
                        entry_q[ptr_q] <= entry_q[prev_idx];
                        ptr_q          <= prev_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.score_bcd = score_q;
    assign bus.rd_score  = entry_q[bus.rd_idx][ENTRY_W-1 -: SCORE_W];
    assign bus.rd_name   = entry_q[bus.rd_idx][NAME_W-1:0];
    assign bus.new_rank  = new_rank_q;
    assign bus.state     = state_q;
    assign bus.busy      = (state_q == ST_CHECK) || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_score_board_ctrl.sv
// Directed bench for score_board_ctrl with DIGITS=2, DEPTH=4, NAME_LEN=5,
// LETTER_W=6; expected values are hand-derived per scenario.
module tb_score_board_ctrl;
    import score_board_ctrl_pkg::*;

    localparam int DIGITS   = 2;
    localparam int DEPTH    = 4;
    localparam int NAME_LEN = 5;
    localparam int LETTER_W = 6;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    score_board_ctrl_if #(
        .DIGITS(DIGITS), .DEPTH(DEPTH), .NAME_LEN(NAME_LEN), .LETTER_W(LETTER_W)
    ) bus ();

    score_board_ctrl #(
        .DIGITS(DIGITS), .DEPTH(DEPTH), .NAME_LEN(NAME_LEN), .LETTER_W(LETTER_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [29:0] mk_name(input int k);
        logic [29:0] r;
        for (int i = 0; i < NAME_LEN; i++) r[i*LETTER_W +: LETTER_W] = 6'(k + i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i);
        bus.rd_idx = 2'(i);
        #1;
    endtask

    task automatic do_reset();
        bus.go = 0; bus.shot = 0; bus.shot_pts = 0; bus.done = 0;
        bus.name_in = '0; bus.name_vld = 0; bus.restart = 0; bus.rd_idx = '0;
        resetn = 1'b0;
        #23;
        resetn = 1'b1;
        tick();
    endtask

    task automatic start_game();
        bus.go = 1; tick(); bus.go = 0;
    endtask

    task automatic shoot(input int pts);
        bus.shot = 1; bus.shot_pts = 2'(pts); tick(); bus.shot = 0; bus.shot_pts = 0;
    endtask

    task automatic play_to(input int n);
        int rem;
        rem = n;
        while (rem >= 3) begin shoot(3); rem -= 3; end
        if (rem > 0) shoot(rem);
    endtask

    task automatic end_game();
        bus.done = 1; tick(); bus.done = 0;
    endtask

    task automatic give_name(input logic [29:0] nm);
        bus.name_in = nm; bus.name_vld = 1; tick(); bus.name_vld = 0;
    endtask

    task automatic do_restart();
        bus.restart = 1; tick(); bus.restart = 0;
    endtask

    // Cycles spent until DONE, or -1 when the budget runs out.
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (bus.state !== ST_DONE && cyc < max) begin tick(); cyc++; end
        if (bus.state !== ST_DONE) cyc = -1;
    endtask

    // Plays one complete game from IDLE and returns to IDLE.
    task automatic full_game(input int score, input logic [29:0] nm);
        int cyc;
        start_game();
        play_to(score);
        end_game();
        tick();
        if (bus.state === ST_NAME) begin
            give_name(nm);
            wait_done(20, cyc);
        end
        do_restart();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.state !== 3'(ST_IDLE)) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE); end
        n_cmp++; if (bus.score_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_score: got %h want 00", bus.score_bcd); end
        n_cmp++; if (bus.new_rank !== 3'd4) begin n_bad++; $display("FAIL reset_rank: got %0d want 4", bus.new_rank); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            n_cmp++; if (bus.rd_score !== 8'h00 || bus.rd_name !== 30'h0) begin
                n_bad++; $display("FAIL reset_entry%0d: got %h/%h want 00/0", i, bus.rd_score, bus.rd_name);
            end
        end
    endtask

    task automatic test_shot_idle();
        shoot(3);
        n_cmp++; if (bus.score_bcd !== 8'h00) begin n_bad++; $display("FAIL idle_shot_score: got %h want 00", bus.score_bcd); end
        n_cmp++; if (bus.state !== 3'(ST_IDLE)) begin n_bad++; $display("FAIL idle_shot_state: got %0d want %0d", bus.state, ST_IDLE); end
    endtask

    task automatic test_zero_score();
        start_game();
        end_game();
        n_cmp++; if (bus.state !== 3'(ST_CHECK)) begin n_bad++; $display("FAIL zero_check: got %0d want %0d", bus.state, ST_CHECK); end
        tick();
        n_cmp++; if (bus.state !== 3'(ST_DONE)) begin n_bad++; $display("FAIL zero_done: got %0d want %0d", bus.state, ST_DONE); end
        n_cmp++; if (bus.new_rank !== 3'd4) begin n_bad++; $display("FAIL zero_rank: got %0d want 4", bus.new_rank); end
        do_restart();
        n_cmp++; if (bus.state !== 3'(ST_IDLE)) begin n_bad++; $display("FAIL zero_restart: got %0d want %0d", bus.state, ST_IDLE); end
    endtask

    task automatic test_basic();
        int cyc;
        start_game();
        n_cmp++; if (bus.state !== 3'(ST_PLAY)) begin n_bad++; $display("FAIL basic_play: got %0d want %0d", bus.state, ST_PLAY); end
        shoot(3); shoot(3); shoot(3); shoot(2);
        n_cmp++; if (bus.score_bcd !== 8'h11) begin n_bad++; $display("FAIL basic_score: got %h want 11", bus.score_bcd); end
        end_game();
        n_cmp++; if (bus.state !== 3'(ST_CHECK) || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_check: got state %0d busy %b want %0d/1", bus.state, bus.busy, ST_CHECK);
        end
        tick();
        n_cmp++; if (bus.state !== 3'(ST_NAME) || bus.new_rank !== 3'd0) begin
            n_bad++; $display("FAIL basic_name: got state %0d rank %0d want %0d/0", bus.state, bus.new_rank, ST_NAME);
        end
        give_name(mk_name(1));
        n_cmp++; if (bus.state !== 3'(ST_SHIFT) || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_shift: got state %0d busy %b want %0d/1", bus.state, bus.busy, ST_SHIFT);
        end
        wait_done(20, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL basic_shift_cycles: got %0d want 4", cyc); end
        set_rd(0);
        n_cmp++; if (bus.rd_score !== 8'h11 || bus.rd_name !== mk_name(1)) begin
            n_bad++; $display("FAIL basic_entry0: got %h/%h want 11/%h", bus.rd_score, bus.rd_name, mk_name(1));
        end
        set_rd(1);
        n_cmp++; if (bus.rd_score !== 8'h00) begin n_bad++; $display("FAIL basic_entry1: got %h want 00", bus.rd_score); end
        do_restart();
    endtask

    task automatic test_rank_insert();
        int cyc;
        int exp_s [DEPTH];
        int exp_k [DEPTH];
        do_reset();
        full_game(10, mk_name(10));
        full_game(20, mk_name(20));
        full_game(30, mk_name(30));
        full_game(40, mk_name(40));
        exp_s = '{40, 30, 20, 10};
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            n_cmp++; if (bus.rd_score !== to_bcd(exp_s[i])) begin
                n_bad++; $display("FAIL fill_entry%0d: got %h want %h", i, bus.rd_score, to_bcd(exp_s[i]));
            end
        end
        start_game();
        play_to(30);
        end_game();
        tick();
        n_cmp++; if (bus.new_rank !== 3'd2 || bus.state !== 3'(ST_NAME)) begin
            n_bad++; $display("FAIL insert_rank: got rank %0d state %0d want 2/%0d", bus.new_rank, bus.state, ST_NAME);
        end
        give_name(mk_name(50));
        wait_done(20, cyc);
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL insert_cycles: got %0d want 2", cyc); end
        exp_s = '{40, 30, 30, 20};
        exp_k = '{40, 30, 50, 20};
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            n_cmp++; if (bus.rd_score !== to_bcd(exp_s[i]) || bus.rd_name !== mk_name(exp_k[i])) begin
                n_bad++; $display("FAIL insert_entry%0d: got %h/%h want %h/%h", i, bus.rd_score, bus.rd_name,
                                  to_bcd(exp_s[i]), mk_name(exp_k[i]));
            end
        end
        do_restart();
    endtask

    task automatic test_no_qualify();
        int exp_s [DEPTH];
        start_game();
        play_to(20);
        end_game();
        tick();
        n_cmp++; if (bus.state !== 3'(ST_DONE) || bus.new_rank !== 3'd4) begin
            n_bad++; $display("FAIL tie_bottom: got state %0d rank %0d want %0d/4", bus.state, bus.new_rank, ST_DONE);
        end
        exp_s = '{40, 30, 30, 20};
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            n_cmp++; if (bus.rd_score !== to_bcd(exp_s[i])) begin
                n_bad++; $display("FAIL unchanged_entry%0d: got %h want %h", i, bus.rd_score, to_bcd(exp_s[i]));
            end
        end
        do_restart();
    endtask

    task automatic test_shot_with_done();
        start_game();
        play_to(5);
        bus.shot = 1; bus.shot_pts = 2'd2; bus.done = 1;
        tick();
        bus.shot = 0; bus.shot_pts = 0; bus.done = 0;
        n_cmp++; if (bus.score_bcd !== 8'h07 || bus.state !== 3'(ST_CHECK)) begin
            n_bad++; $display("FAIL shot_done: got score %h state %0d want 07/%0d", bus.score_bcd, bus.state, ST_CHECK);
        end
        tick();
        n_cmp++; if (bus.state !== 3'(ST_DONE) || bus.score_bcd !== 8'h07) begin
            n_bad++; $display("FAIL shot_done_final: got state %0d score %h want %0d/07", bus.state, bus.score_bcd, ST_DONE);
        end
        do_restart();
    endtask

    task automatic test_saturate_and_reset();
        start_game();
        play_to(98);
        n_cmp++; if (bus.score_bcd !== 8'h98) begin n_bad++; $display("FAIL sat_98: got %h want 98", bus.score_bcd); end
        shoot(3);
        n_cmp++; if (bus.score_bcd !== 8'h99) begin n_bad++; $display("FAIL sat_99: got %h want 99", bus.score_bcd); end
        shoot(1);
        n_cmp++; if (bus.score_bcd !== 8'h99) begin n_bad++; $display("FAIL sat_hold: got %h want 99", bus.score_bcd); end
        end_game();
        tick();
        n_cmp++; if (bus.state !== 3'(ST_NAME) || bus.new_rank !== 3'd0) begin
            n_bad++; $display("FAIL sat_rank: got state %0d rank %0d want %0d/0", bus.state, bus.new_rank, ST_NAME);
        end
        do_restart();
        n_cmp++; if (bus.state !== 3'(ST_NAME)) begin n_bad++; $display("FAIL restart_in_name: got %0d want %0d", bus.state, ST_NAME); end
        give_name(mk_name(60));
        tick();
        tick();
        n_cmp++; if (bus.state !== 3'(ST_SHIFT)) begin n_bad++; $display("FAIL mid_shift: got %0d want %0d", bus.state, ST_SHIFT); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (bus.state !== 3'(ST_IDLE) || bus.score_bcd !== 8'h00 || bus.busy !== 1'b0 || bus.new_rank !== 3'd4) begin
            n_bad++; $display("FAIL async_reset: got state %0d score %h busy %b rank %0d want 0/00/0/4",
                              bus.state, bus.score_bcd, bus.busy, bus.new_rank);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            n_cmp++; if (bus.rd_score !== 8'h00 || bus.rd_name !== 30'h0) begin
                n_bad++; $display("FAIL async_reset_entry%0d: got %h/%h want 00/0", i, bus.rd_score, bus.rd_name);
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_shot_idle();
        test_zero_score();
        test_basic();
        test_rank_insert();
        test_no_qualify();
        test_shot_with_done();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
